// File: rtl/dma_mm2s_checker_if.sv
// AXI4-Stream channel between the DMA MM2S port (master) and the checker (slave).
interface dma_mm2s_checker_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, tkeep, tlast, tvalid, input  tready);
    modport slave  (input  tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/dma_mm2s_checker.sv
// Sinks a DMA MM2S stream, checks each packet against an index ramp (0..PKT_BEATS-1),
// and counts packets and bad beats for a run started/stopped by a PS GPIO bit.
module dma_mm2s_checker #(
    parameter int DATA_W    = 32,
    parameter int PKT_BEATS = 128
) (
    input  logic              FCLK_CLK0,
    input  logic              FCLK_RESET0_N,
    input  logic              enable,
    input  logic [15:0]       num_pkts,
    dma_mm2s_checker_if.slave S_AXIS_MM2S,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count,
    output logic              err_data,
    output logic              err_last,
    output logic              err_keep,
    output logic              pkt_done,
    output logic              busy,
    output logic              done_all
);
    localparam int               IDX_W    = $clog2(PKT_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BEATS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] beat_idx;
    logic             beat_ok;
    logic             at_last_idx;
    logic             bad_data;
    logic             bad_keep;
    logic             bad_last;
    logic             final_pkt;
    logic [15:0]      pkt_inc;

    // Ready depends only on the state register, never on tvalid.
    assign S_AXIS_MM2S.tready = (state == RUN);
    assign beat_ok            = S_AXIS_MM2S.tvalid && (state == RUN);

    assign at_last_idx = (beat_idx == LAST_IDX);
    assign bad_data    = (S_AXIS_MM2S.tdata != DATA_W'(beat_idx));
    assign bad_keep    = (S_AXIS_MM2S.tkeep != '1);
    assign bad_last    = (S_AXIS_MM2S.tlast != at_last_idx);
    assign pkt_inc     = pkt_count + 16'd1;
    assign final_pkt   = S_AXIS_MM2S.tlast && (num_pkts != 16'd0) && (pkt_inc == num_pkts);

    always_ff @(posedge FCLK_CLK0 or negedge FCLK_RESET0_N) begin
        if (!FCLK_RESET0_N) begin
            state     <= IDLE;
            beat_idx  <= '0;
            pkt_count <= 16'd0;
            err_count <= 16'd0;
            err_data  <= 1'b0;
            err_last  <= 1'b0;
            err_keep  <= 1'b0;
            pkt_done  <= 1'b0;
            busy      <= 1'b0;
            done_all  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        done_all  <= 1'b0;
                        beat_idx  <= '0;
                        pkt_count <= 16'd0;
                        err_count <= 16'd0;
                        err_data  <= 1'b0;
                        err_last  <= 1'b0;
                        err_keep  <= 1'b0;
                    end
                end
                RUN: begin
                    if (beat_ok) begin
                        err_data <= err_data | bad_data;
                        err_keep <= err_keep | bad_keep;
                        err_last <= err_last | bad_last;
                        if ((bad_data || bad_keep || bad_last) && (err_count != 16'hFFFF))
                            err_count <= err_count + 16'd1;
                        // A missing tlast still closes the packet slot so the ramp restarts.
                        beat_idx <= (S_AXIS_MM2S.tlast || at_last_idx) ? '0 : beat_idx + 1'b1;
                        if (S_AXIS_MM2S.tlast) begin
                            pkt_count <= pkt_inc;
                            pkt_done  <= 1'b1;
                        end
                    end
                    if (beat_ok && final_pkt) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done_all <= 1'b1;
                    end else if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state    <= IDLE;
                        done_all <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done_all <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_mm2s_checker.sv
// Randomized bench for dma_mm2s_checker: a packet-level model predicts every output
// each cycle, plus directed scenarios with hand-computed expectations.
module tb_dma_mm2s_checker;
    localparam int DATA_W    = 32;
    localparam int PKT_BEATS = 128;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic [15:0] num_pkts = 16'd0;
    logic [15:0] pkt_count, err_count;
    logic        err_data, err_last, err_keep, pkt_done, busy, done_all;
    bit          en_cur   = 1'b0;
    int          n_cmp    = 0;
    int          n_bad    = 0;

    dma_mm2s_checker_if #(.DATA_W(DATA_W)) s_axis ();

    dma_mm2s_checker #(.DATA_W(DATA_W), .PKT_BEATS(PKT_BEATS)) dut (
        .FCLK_CLK0     (clk),
        .FCLK_RESET0_N (rst_n),
        .enable        (enable),
        .num_pkts      (num_pkts),
        .S_AXIS_MM2S   (s_axis),
        .pkt_count     (pkt_count),
        .err_count     (err_count),
        .err_data      (err_data),
        .err_last      (err_last),
        .err_keep      (err_keep),
        .pkt_done      (pkt_done),
        .busy          (busy),
        .done_all      (done_all)
    );

    always #5 clk = ~clk;

    // Reference: run phase (0 idle, 1 run, 2 done), position in packet, tallies.
    typedef struct {
        int st;
        int idx;
        int pkts;
        int errs;
        bit ed, el, ek, pd;
    } model_t;

    model_t m;

    function automatic model_t zero_model();
        model_t z;
        z.st = 0; z.idx = 0; z.pkts = 0; z.errs = 0;
        z.ed = 0; z.el = 0; z.ek = 0; z.pd = 0;
        return z;
    endfunction

    function automatic model_t step(model_t c, bit en, int np, bit v, logic [31:0] d,
                                    bit k_full, bit l);
        model_t n;
        n    = c;
        n.pd = 0;
        if (c.st == 0) begin
            if (en) begin
                n    = zero_model();
                n.st = 1;
            end
        end else if (c.st == 1) begin
            if (v) begin
                bit want_last;
                bit any_err;
                want_last = (c.idx == PKT_BEATS - 1);
                any_err   = (d != 32'(c.idx)) || !k_full || (l != want_last);
                if (d != 32'(c.idx)) n.ed = 1;
                if (!k_full)         n.ek = 1;
                if (l != want_last)  n.el = 1;
                if (any_err)         n.errs = (c.errs < 65535) ? c.errs + 1 : 65535;
                n.idx = (l || want_last) ? 0 : c.idx + 1;
                if (l) begin
                    n.pkts = (c.pkts + 1) % 65536;
                    n.pd   = 1;
                end
            end
            if (v && l && np != 0 && n.pkts == np) n.st = 2;
            else if (!en)                          n.st = 0;
        end else if (!en) begin
            n.st = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= zero_model();
        else        m <= step(m, enable, int'(num_pkts), s_axis.tvalid, s_axis.tdata,
                              (s_axis.tkeep == '1), s_axis.tlast);
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("tready",    int'(s_axis.tready), int'(m.st == 1));
        check("busy",      int'(busy),          int'(m.st == 1));
        check("done_all",  int'(done_all),      int'(m.st == 2));
        check("pkt_count", int'(pkt_count),     m.pkts);
        check("err_count", int'(err_count),     m.errs);
        check("err_data",  int'(err_data),      int'(m.ed));
        check("err_last",  int'(err_last),      int'(m.el));
        check("err_keep",  int'(err_keep),      int'(m.ek));
        check("pkt_done",  int'(pkt_done),      int'(m.pd));
    end

    task automatic cycle(input bit v, input logic [31:0] d, input bit l, input bit kbad,
                         output bit acc);
        @(negedge clk);
        enable        = en_cur;
        s_axis.tvalid = v;
        s_axis.tdata  = d;
        s_axis.tlast  = l;
        s_axis.tkeep  = kbad ? 4'b1011 : 4'b1111;
        acc           = v && s_axis.tready;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 32'd0, 1'b0, 1'b0, acc);
    endtask

    task automatic set_en(input bit e);
        en_cur = e;
        idle(1);
    endtask

    // Sends beats 0..nb-1 carrying their index; gives up once the sink stops being ready.
    task automatic send_pkt(input int nb, input int last_at, input int bad_i, input int kbad_i,
                            input int vpct, input int drop_i);
        int          i;
        int          guard;
        bit          acc;
        bit          v;
        logic [31:0] d;
        i     = 0;
        guard = 0;
        while (i < nb) begin
            v = ($urandom_range(0, 99) < vpct);
            if (i == drop_i) begin
                v      = 1'b1;
                en_cur = 1'b0;
            end
            d = (i == bad_i) ? 32'hDEAD : 32'(i);
            cycle(v, d, (i == last_at), (i == kbad_i), acc);
            if (acc) i++;
            else if (!s_axis.tready) return;
            guard++;
            if (guard > 5000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: got %0d beats expected %0d", i, nb);
                return;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '1;
        s_axis.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tready",    int'(s_axis.tready), 0);
        check("rst_pkt_count", int'(pkt_count),     0);
        check("rst_err_count", int'(err_count),     0);
        check("rst_flags",     int'({err_data, err_last, err_keep, pkt_done, busy, done_all}), 0);

        // Two clean packets with a packet limit of 2.
        num_pkts = 16'd2;
        set_en(1'b1);
        send_pkt(128, 127, -1, -1, 100, -1);
        send_pkt(128, 127, -1, -1, 100, -1);
        idle(3);
        check("clean_pkt_count", int'(pkt_count),     2);
        check("clean_done_all",  int'(done_all),      1);
        check("clean_tready",    int'(s_axis.tready), 0);
        check("clean_err_count", int'(err_count),     0);
        check("clean_flags",     int'({err_data, err_last, err_keep}), 0);
        set_en(1'b0);
        idle(2);

        // One corrupted data word at beat 5.
        num_pkts = 16'd0;
        set_en(1'b1);
        send_pkt(128, 127, 5, -1, 100, -1);
        idle(2);
        check("bad5_err_data",  int'(err_data),  1);
        check("bad5_err_count", int'(err_count), 1);
        check("bad5_pkt_count", int'(pkt_count), 1);
        check("bad5_err_last",  int'(err_last),  0);
        set_en(1'b0);

        // Early tlast at beat 63, then a clean packet starting from 0.
        set_en(1'b1);
        send_pkt(64, 63, -1, -1, 100, -1);
        send_pkt(128, 127, -1, -1, 100, -1);
        idle(2);
        check("early_err_last",  int'(err_last),  1);
        check("early_err_data",  int'(err_data),  0);
        check("early_err_count", int'(err_count), 1);
        check("early_pkt_count", int'(pkt_count), 2);
        set_en(1'b0);

        // Missing tlast, then a clean packet, then data+keep errors on one beat.
        set_en(1'b1);
        send_pkt(128, -1, -1, -1, 100, -1);
        idle(2);
        check("miss_err_last",  int'(err_last),  1);
        check("miss_pkt_count", int'(pkt_count), 0);
        check("miss_err_count", int'(err_count), 1);
        send_pkt(128, 127, -1, -1, 100, -1);
        idle(1);
        check("wrap_err_data",  int'(err_data),  0);
        check("wrap_pkt_count", int'(pkt_count), 1);
        send_pkt(128, 127, 10, 10, 100, -1);
        idle(1);
        check("keep_err_keep",  int'(err_keep),  1);
        check("keep_err_count", int'(err_count), 2);
        set_en(1'b0);

        // 50% valid, enable dropped mid-packet alongside an accepted beat.
        set_en(1'b1);
        send_pkt(128, 127, -1, -1, 50, -1);
        send_pkt(128, 127, -1, -1, 50, 37);
        check("drop_busy",      int'(busy),          0);
        check("drop_tready",    int'(s_axis.tready), 0);
        check("drop_pkt_count", int'(pkt_count),     1);
        begin
            bit acc;
            for (int k = 0; k < 6; k++)
                cycle(1'($urandom_range(0, 1)), 32'd99, 1'b1, 1'b0, acc);
        end
        check("hold_pkt_count", int'(pkt_count), 1);
        check("hold_err_count", int'(err_count), 0);
        set_en(1'b1);
        @(negedge clk);
        check("reen_pkt_count", int'(pkt_count), 0);
        check("reen_busy",      int'(busy),      1);
        set_en(1'b0);

        // Random runs.
        for (int r = 0; r < 6; r++) begin
            idle(2);
            num_pkts = 16'($urandom_range(1, 3));
            set_en(1'b1);
            for (int p = 0; p < int'(num_pkts) + 2; p++) begin
                int kind;
                int vp;
                int la;
                kind = $urandom_range(0, 4);
                vp   = $urandom_range(30, 100);
                la   = $urandom_range(1, 126);
                case (kind)
                    1:       send_pkt(128, 127, $urandom_range(0, 127), -1, vp, -1);
                    2:       send_pkt(128, 127, -1, $urandom_range(0, 127), vp, -1);
                    3:       send_pkt(la + 1, la, -1, -1, vp, -1);
                    4:       send_pkt(128, -1, -1, -1, vp, -1);
                    default: send_pkt(128, 127, -1, -1, vp, -1);
                endcase
            end
            idle(3);
            set_en(1'b0);
        end

        // Asynchronous reset pulse mid-packet, then a clean two-packet run.
        idle(2);
        num_pkts = 16'd2;
        set_en(1'b1);
        send_pkt(128, 127, -1, -1, 100, -1);
        send_pkt(40, -1, 3, -1, 100, -1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tready",    int'(s_axis.tready), 0);
        check("arst_pkt_count", int'(pkt_count),     0);
        check("arst_err_count", int'(err_count),     0);
        check("arst_flags",     int'({err_data, err_last, err_keep, pkt_done, busy, done_all}), 0);
        #1 rst_n = 1'b1;
        idle(1);
        send_pkt(128, 127, -1, -1, 100, -1);
        send_pkt(128, 127, -1, -1, 100, -1);
        idle(3);
        check("post_pkt_count", int'(pkt_count),     2);
        check("post_done_all",  int'(done_all),      1);
        check("post_tready",    int'(s_axis.tready), 0);
        check("post_err_count", int'(err_count),     0);
        check("post_flags",     int'({err_data, err_last, err_keep}), 0);
        set_en(1'b0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
